// File: rtl/cga_scandbl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cga_scandbl_pkg
//  Description : Shared types and width helpers for the CGA/MDA scan doubler.
//  Revision    : 1.0  initial release
// ============================================================================
package cga_scandbl_pkg;

    typedef enum logic {
        MODE_BYPASS = 1'b0,
        MODE_DOUBLE = 1'b1
    } mode_t;

    // Stored word is {display_enable, video}
    function automatic int rec_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int de_bit(input int data_w);
        return data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cga_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : cga_line_ram
//  Description : One line-store bank, single clock, one write port and one
//                registered read port.
//  Revision    : 1.0  initial release
// ============================================================================
module cga_line_ram
    import cga_scandbl_pkg::*;
#(
    parameter int WIDTH  = rec_w(4),
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/cga_scandoubler_p.sv
`default_nettype none
// ============================================================================
//  Module      : cga_scandoubler_p
//  Description : CGA/MDA line doubler, ping-pong line store replayed twice per
//                source line, with per-line bypass. Optional SCANDBL_SCANLINE_EN
//                adds scanline_en to blank the second pass.
//  Revision    : 1.0  initial release
// ============================================================================
module cga_scandoubler_p
    import cga_scandbl_pkg::*;
#(
    parameter int   DATA_W   = 4,
    parameter int   ADDR_W   = 10,
    parameter int   H_TOTAL  = 911,
    parameter int   HS_START = 720,
    parameter int   HS_WIDTH = 160,
    parameter logic HS_POL   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_reset,
    input  logic              dbl_en,
    input  logic              hsync,
    input  logic              display_enable,
    input  logic [DATA_W-1:0] video,
`ifdef SCANDBL_SCANLINE_EN
    input  logic              scanline_en,
`endif
    output logic              dbl_hsync,
    output logic [DATA_W-1:0] dbl_video,
    output logic              dbl_display_enable,
    output logic              dbl_odd
);

    localparam int c_REC_W  = rec_w(DATA_W);
    localparam int c_DE_BIT = de_bit(DATA_W);
    localparam int c_DEPTH  = 2**ADDR_W;
    localparam int c_FC_W   = $clog2(H_TOTAL + 1);

    if (HS_START + HS_WIDTH > H_TOTAL + 1) begin : g_hs_window_chk
        $error("cga_scandoubler_p: hsync window extends past H_TOTAL");
    end

    logic              r_lr_q;
    logic              r_select;
    logic              r_phase;
    logic [ADDR_W-1:0] r_hcount_slow;
    logic [c_FC_W-1:0] r_hcount_fast;
    mode_t             r_mode;
    logic              w_line_evt;

    assign w_line_evt = line_reset & ~r_lr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lr_q        <= 1'b0;
            r_select      <= 1'b0;
            r_phase       <= 1'b0;
            r_hcount_slow <= '0;
            r_hcount_fast <= '0;
            r_mode        <= MODE_DOUBLE;
            dbl_odd       <= 1'b0;
        end else begin
            r_lr_q <= line_reset;
            if (w_line_evt) begin
                r_select      <= ~r_select;
                r_phase       <= 1'b0;
                r_hcount_slow <= '0;
                r_hcount_fast <= '0;
                dbl_odd       <= 1'b0;
                r_mode        <= dbl_en ? MODE_DOUBLE : MODE_BYPASS;
            end else begin
                r_phase <= ~r_phase;
                // Saturate so an over-long line never wraps onto its own start
                if (r_phase && (r_hcount_slow != {ADDR_W{1'b1}})) begin
                    r_hcount_slow <= r_hcount_slow + 1'b1;
                end
                if (r_hcount_fast == c_FC_W'(H_TOTAL)) begin
                    r_hcount_fast <= '0;
                    if (r_mode == MODE_DOUBLE) begin
                        dbl_odd <= ~dbl_odd;
                    end
                end else begin
                    r_hcount_fast <= r_hcount_fast + 1'b1;
                end
            end
        end
    end

    logic [c_REC_W-1:0] w_wr_data;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [c_REC_W-1:0] w_rd_data [2];
    logic               w_rd_valid;
    logic               w_hs_win;

    assign w_wr_data  = {display_enable, video};
    assign w_rd_addr  = ADDR_W'(r_hcount_fast);
    assign w_rd_valid = int'(r_hcount_fast) < c_DEPTH;
    assign w_hs_win   = (int'(r_hcount_fast) >= HS_START) &&
                        (int'(r_hcount_fast) <  HS_START + HS_WIDTH);

    // Bank 0 (A) is written while select=1, bank 1 (B) while select=0
    for (genvar i = 0; i < 2; i++) begin : g_bank
        cga_line_ram #(
            .WIDTH  (c_REC_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk     (clk),
            .wr_en   ((i == 0) ? r_select : ~r_select),
            .wr_addr (r_hcount_slow),
            .wr_data (w_wr_data),
            .rd_addr (w_rd_addr),
            .rd_data (w_rd_data[i])
        );
    end

    logic              r_rd_sel1;
    logic              r_rd_valid1;
    logic              r_hs1;
    mode_t             r_mode1;
    logic [c_REC_W:0]  r_byp1;
`ifdef SCANDBL_SCANLINE_EN
    logic              r_odd1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_sel1   <= 1'b0;
            r_rd_valid1 <= 1'b0;
            r_hs1       <= 1'b0;
            r_mode1     <= MODE_DOUBLE;
            r_byp1      <= '0;
`ifdef SCANDBL_SCANLINE_EN
            r_odd1      <= 1'b0;
`endif
        end else begin
            r_rd_sel1   <= r_select;
            r_rd_valid1 <= w_rd_valid;
            r_hs1       <= w_hs_win;
            r_mode1     <= r_mode;
            r_byp1      <= {hsync, display_enable, video};
`ifdef SCANDBL_SCANLINE_EN
            r_odd1      <= dbl_odd;
`endif
        end
    end

    logic [c_REC_W-1:0] w_rd_word;
    logic               w_dark;

    assign w_rd_word = r_rd_sel1 ? w_rd_data[1] : w_rd_data[0];
`ifdef SCANDBL_SCANLINE_EN
    // Mask follows the pass whose pixels are currently leaving the pipeline
    assign w_dark = scanline_en & r_odd1;
`else
    assign w_dark = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbl_hsync          <= ~HS_POL;
            dbl_video          <= '0;
            dbl_display_enable <= 1'b0;
        end else if (r_mode1 == MODE_DOUBLE) begin
            dbl_hsync          <= r_hs1 ? HS_POL : ~HS_POL;
            dbl_display_enable <= r_rd_valid1 & w_rd_word[c_DE_BIT];
            dbl_video          <= (r_rd_valid1 && !w_dark) ? w_rd_word[DATA_W-1:0] : '0;
        end else begin
            dbl_hsync          <= r_byp1[c_REC_W];
            dbl_display_enable <= r_byp1[c_DE_BIT];
            dbl_video          <= r_byp1[DATA_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cga_scandoubler_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cga_scandoubler_p
//  Description : Self-checking bench for cga_scandoubler_p against a
//                line-level behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cga_scandoubler_p;

    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 10;
    localparam int H_TOTAL  = 911;
    localparam int HS_START = 720;
    localparam int HS_WIDTH = 160;
    localparam bit HS_POL   = 1'b1;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int PERIOD   = H_TOTAL + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              line_reset = 1'b0;
    logic              dbl_en = 1'b1;
    logic              hsync = 1'b0;
    logic              display_enable = 1'b0;
    logic [DATA_W-1:0] video = '0;
`ifdef SCANDBL_SCANLINE_EN
    logic              scanline_en = 1'b0;
`endif
    logic              dbl_hsync;
    logic [DATA_W-1:0] dbl_video;
    logic              dbl_display_enable;
    logic              dbl_odd;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cga_scandoubler_p #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .H_TOTAL  (H_TOTAL),
        .HS_START (HS_START),
        .HS_WIDTH (HS_WIDTH),
        .HS_POL   (HS_POL)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .line_reset         (line_reset),
        .dbl_en             (dbl_en),
        .hsync              (hsync),
        .display_enable     (display_enable),
        .video              (video),
`ifdef SCANDBL_SCANLINE_EN
        .scanline_en        (scanline_en),
`endif
        .dbl_hsync          (dbl_hsync),
        .dbl_video          (dbl_video),
        .dbl_display_enable (dbl_display_enable),
        .dbl_odd            (dbl_odd)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        bit              hs;
        bit              de;
        logic [DATA_W-1:0] vid;
        bit              known;
    } exp_t;

    int   mem_a [DEPTH];
    int   mem_b [DEPTH];
    int   m_n;
    bit   m_sel;
    bit   m_mode;
    bit   m_prev_lr;
    exp_t exp_q [$];
    exp_t cur;
    exp_t m_e;
    int   m_fast;
    int   m_word;
    int   m_waddr;

    function automatic exp_t reset_exp();
        exp_t r;
        r.hs = !HS_POL; r.de = 1'b0; r.vid = '0; r.known = 1'b1;
        return r;
    endfunction

    function automatic bit odd_now(input int n, input bit mode);
        return mode && (((n / PERIOD) % 2) == 1);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n = 0; m_sel = 1'b0; m_mode = 1'b1; m_prev_lr = 1'b0;
            cur = reset_exp();
            exp_q = {};
            exp_q.push_back(reset_exp());
        end else begin
            m_fast = m_n % PERIOD;
            if (m_mode) begin
                m_e.hs = (m_fast >= HS_START && m_fast < HS_START + HS_WIDTH) ? HS_POL : !HS_POL;
                if (m_fast >= DEPTH) begin
                    m_e.de = 1'b0; m_e.vid = '0; m_e.known = 1'b1;
                end else begin
                    m_word = m_sel ? mem_b[m_fast] : mem_a[m_fast];
                    m_e.known = (m_word >= 0);
                    m_e.de    = m_word[DATA_W];
                    m_e.vid   = m_word[DATA_W-1:0];
                end
`ifdef SCANDBL_SCANLINE_EN
                if (scanline_en && odd_now(m_n, m_mode)) m_e.vid = '0;
`endif
            end else begin
                m_e.hs = hsync; m_e.de = display_enable; m_e.vid = video; m_e.known = 1'b1;
            end
            exp_q.push_back(m_e);
            cur = exp_q.pop_front();
            m_waddr = (m_n / 2 < DEPTH - 1) ? m_n / 2 : DEPTH - 1;
            if (m_sel) mem_a[m_waddr] = int'({display_enable, video});
            else       mem_b[m_waddr] = int'({display_enable, video});
            if (line_reset && !m_prev_lr) begin
                m_sel = !m_sel; m_n = 0; m_mode = dbl_en;
            end else begin
                m_n++;
            end
            m_prev_lr = line_reset;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit e_odd;
    always @(negedge clk) begin
        if (chk_en) begin
            e_odd = odd_now(m_n, m_mode);
            checks++;
            if (dbl_hsync !== cur.hs || dbl_odd !== e_odd ||
                (cur.known && (dbl_video !== cur.vid || dbl_display_enable !== cur.de))) begin
                errors++;
                $display("FAIL cycle t=%0t got hs=%b de=%b vid=%h odd=%b exp hs=%b de=%b vid=%h odd=%b known=%b",
                         $time, dbl_hsync, dbl_display_enable, dbl_video, dbl_odd,
                         cur.hs, cur.de, cur.vid, e_odd, cur.known);
            end
        end
    end

    task automatic lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    // kind: 0 random, 1 ramp. flip_at<0: no mid-line dbl_en change.
    task automatic run_line(input int len, input int kind, input bit dbl, input int flip_at,
                            input bit end_evt, input bit scan, input bit lit_chk);
        int rises[2];
        int falls[2];
        int nr = 0;
        int nf = 0;
        bit prev_hs = !HS_POL;
        rises = '{-1, -1};
        falls = '{-1, -1};
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            if (lit_chk) begin
                if (j == 102) begin
                    lit("ramp_pass0_video", int'(dbl_video), 4);
                    lit("ramp_pass0_de", int'(dbl_display_enable), 1);
                    lit("ramp_pass0_odd", int'(dbl_odd), 0);
                end
                if (j == 1014) begin
                    lit("ramp_pass1_video", int'(dbl_video), 4);
                    lit("ramp_pass1_odd", int'(dbl_odd), 1);
                end
                if (dbl_hsync == HS_POL && prev_hs != HS_POL && nr < 2) rises[nr++] = j;
                if (dbl_hsync != HS_POL && prev_hs == HS_POL && nf < 2) falls[nf++] = j;
                prev_hs = dbl_hsync;
            end
            line_reset = end_evt && (j == len - 1);
            dbl_en     = (flip_at >= 0 && j >= flip_at) ? !dbl : dbl;
`ifdef SCANDBL_SCANLINE_EN
            scanline_en = scan;
`endif
            if (kind == 1) begin
                video = DATA_W'((j >> 1) & 15);
                display_enable = 1'b1;
                hsync = 1'b0;
            end else begin
                video = DATA_W'($urandom);
                display_enable = 1'($urandom);
                hsync = 1'($urandom);
            end
        end
        if (lit_chk) begin
            lit("hs_rise0", rises[0], HS_START + 2);
            lit("hs_fall0", falls[0], HS_START + HS_WIDTH + 2);
            lit("hs_rise1", rises[1], HS_START + 2 + PERIOD);
            lit("hs_fall1", falls[1], HS_START + HS_WIDTH + 2 + PERIOD);
        end
        if (!scan) begin end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = -1;
            mem_b[i] = -1;
        end
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        lit("reset_hs", int'(dbl_hsync), int'(!HS_POL));
        lit("reset_video", int'(dbl_video), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run_line(500, 0, 1'b1, -1, 1'b1, 1'b0, 1'b0);
        // ramp line, then its replay with hand-computed expectations
        run_line(1824, 1, 1'b1, -1, 1'b1, 1'b0, 1'b0);
        run_line(1824, 0, 1'b1, -1, 1'b1, 1'b0, 1'b1);
        // overflowing line followed by its replay
        run_line(2200, 0, 1'b1, -1, 1'b1, 1'b0, 1'b0);
        run_line(1824, 0, 1'b1, -1, 1'b1, 1'b0, 1'b0);
        // dbl_en drops mid-line: doubling holds until the next event
        run_line(1824, 0, 1'b1, 900, 1'b1, 1'b0, 1'b0);
        run_line(1000, 0, 1'b0, -1, 1'b1, 1'b0, 1'b0);
        // no line events: free-running replay
        run_line(3000, 0, 1'b1, -1, 1'b1, 1'b0, 1'b0);

        // reset mid-line
        run_line(700, 0, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        lit("midreset_hs", int'(dbl_hsync), int'(!HS_POL));
        lit("midreset_video", int'(dbl_video), 0);
        lit("midreset_de", int'(dbl_display_enable), 0);
        lit("midreset_odd", int'(dbl_odd), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_line(600, 0, 1'b1, -1, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            run_line(int'($urandom_range(800, 2400)), 0, 1'($urandom),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(100, 700)) : -1,
                     1'b1, 1'($urandom), 1'b0);
        end
        run_line(200, 0, 1'b1, -1, 1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
